// File: rtl/br_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : br_result_queue
// Description : Multi-lane FIFO buffering resolved branch results for the
//               predictor update port. Optional same-PHT-index coalescing is
//               enabled by defining BR_RESULT_QUEUE_COALESCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module br_result_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int PV_W   = 16,
  parameter int IDX_W  = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*ADDR_W-1:0]   in_addr,
  input  logic [LANES-1:0]          in_taken,
  input  logic [LANES-1:0]          in_mispred,
  input  logic [LANES-1:0]          in_cond,
  input  logic [LANES*PV_W-1:0]     in_prev,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_taken,
  output logic                      out_mispred,
  output logic                      out_cond,
  output logic [PV_W-1:0]           out_prev,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + 3 + PV_W;

`ifdef BR_RESULT_QUEUE_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [LANES-1:0] lane_keep;
  logic [AW-1:0]    lane_slot [LANES];
  logic [CW-1:0]    keep_cnt;
  logic [CW-1:0]    enq_cnt;
  logic             deq;

  assign in_ready = (count_q <= CW'(DEPTH - LANES));
  assign deq      = (count_q != '0) && out_ready;

  // A lane is dropped when a lower valid lane in the same cycle hits the same PHT index.
  always_comb begin
    lane_keep = in_valid;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < i; j++) begin
        if (COALESCE && in_valid[i] && in_valid[j] &&
            (in_addr[i*ADDR_W+2 +: IDX_W] == in_addr[j*ADDR_W+2 +: IDX_W])) begin
          lane_keep[i] = 1'b0;
        end
      end
    end
  end

  // Kept lanes pack into consecutive slots from the tail; pointer math wraps naturally.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i] = tail_q + keep_cnt[AW-1:0];
      if (lane_keep[i]) begin
        keep_cnt = keep_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    enq_cnt    = in_ready ? keep_cnt : '0;
    head_d     = head_q + AW'(deq);
    tail_d     = tail_q + enq_cnt[AW-1:0];
    count_d    = count_q + enq_cnt - CW'(deq);
    overflow_d = overflow_q | (~in_ready & (|in_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && in_ready) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_keep[i]) begin
          mem_q[lane_slot[i]] <= {in_addr[i*ADDR_W +: ADDR_W], in_taken[i], in_mispred[i],
                                  in_cond[i], in_prev[i*PV_W +: PV_W]};
        end
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign {out_addr, out_taken, out_mispred, out_cond, out_prev} = mem_q[head_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_br_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_result_queue
// Description : Scoreboard bench for br_result_queue (LANES=2, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_result_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic        taken;
    logic        mispred;
    logic        cond;
    logic [15:0] prev;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [63:0] in_addr;
  logic [1:0]  in_taken, in_mispred, in_cond;
  logic [31:0] in_prev;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_addr;
  logic        out_taken, out_mispred, out_cond;
  logic [15:0] out_prev;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;

  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];

  br_result_queue #(.LANES(2), .DEPTH(8), .ADDR_W(32), .PV_W(16), .IDX_W(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken),
    .in_mispred(in_mispred), .in_cond(in_cond), .in_prev(in_prev),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_taken(out_taken),
    .out_mispred(out_mispred), .out_cond(out_cond), .out_prev(out_prev),
    .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      ent_t act;
      act = '{out_addr, out_taken, out_mispred, out_cond, out_prev};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL deq_unexpected: got addr=%h, required no entry", out_addr);
      end else begin
        ent_t exp;
        exp = sb.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL deq_entry: got %h, required %h", act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = '0; in_addr = '0; in_taken = '0; in_mispred = '0; in_cond = '0; in_prev = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [2:0] tmc,
                          input logic [15:0] pv, input bit exp);
    in_valid[l]           = 1'b1;
    in_addr[l*32 +: 32]   = a;
    in_taken[l]           = tmc[2];
    in_mispred[l]         = tmc[1];
    in_cond[l]            = tmc[0];
    in_prev[l*16 +: 16]   = pv;
    if (exp) sb.push_back('{a, tmc[2], tmc[1], tmc[0], pv});
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", {28'd0, count}, 32'd0);
  endtask

  initial begin
    clr_in();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Two lanes, then dequeue both in order
    set_lane(0, 32'h100, 3'b101, 16'h1111, 1'b1);
    set_lane(1, 32'h104, 3'b011, 16'h2222, 1'b1);
    tick(); clr_in();
    chk("two_lane_count", {28'd0, count}, 32'd2);
    chk("two_lane_head", out_addr, 32'h100);
    out_ready = 1'b1;
    tick();
    chk("after_one_deq_head", out_addr, 32'h104);
    tick();
    out_ready = 1'b0;
    chk("two_lane_empty", {28'd0, count}, 32'd0);

    // Only lane 1 valid: no hole at the head
    in_addr[31:0] = 32'hDEAD;
    set_lane(1, 32'h200, 3'b110, 16'h3333, 1'b1);
    tick(); clr_in();
    chk("lane1_count", {28'd0, count}, 32'd1);
    chk("lane1_head", out_addr, 32'h200);
    drain();

    // Advance tail from 3 to 7, then straddle the wrap
    set_lane(0, 32'h10, 3'b000, 16'h0010, 1'b1);
    set_lane(1, 32'h14, 3'b001, 16'h0014, 1'b1);
    tick(); clr_in();
    set_lane(0, 32'h18, 3'b010, 16'h0018, 1'b1);
    set_lane(1, 32'h1C, 3'b100, 16'h001C, 1'b1);
    tick(); clr_in();
    set_lane(0, 32'hA0, 3'b111, 16'h00A0, 1'b1);
    set_lane(1, 32'hA4, 3'b101, 16'h00A4, 1'b1);
    tick(); clr_in();
    chk("wrap_count", {28'd0, count}, 32'd6);
    chk("wrap_in_ready", {31'd0, in_ready}, 32'd1);

    // Enqueue two and dequeue one in the same edge at count=6
    set_lane(0, 32'hB0, 3'b011, 16'h00B0, 1'b1);
    set_lane(1, 32'hB4, 3'b110, 16'h00B4, 1'b1);
    out_ready = 1'b1;
    tick(); clr_in();
    out_ready = 1'b0;
    chk("simul_count", {28'd0, count}, 32'd7);
    chk("simul_overflow", {31'd0, overflow}, 32'd0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);

    // Arrivals while not ready are dropped and flagged
    set_lane(0, 32'hC0, 3'b111, 16'h00C0, 1'b0);
    set_lane(1, 32'hC4, 3'b111, 16'h00C4, 1'b0);
    tick(); clr_in();
    chk("ovf_count", {28'd0, count}, 32'd7);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    drain();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Same PHT index in one cycle: identical address, then aliasing address
`ifdef BR_RESULT_QUEUE_COALESCE_EN
    set_lane(0, 32'h400, 3'b101, 16'h0400, 1'b1);
    set_lane(1, 32'h400, 3'b010, 16'h0401, 1'b0);
    tick(); clr_in();
    chk("same_idx_count", {28'd0, count}, 32'd1);
    set_lane(0, 32'h300, 3'b001, 16'h0300, 1'b1);
    set_lane(1, 32'h1300, 3'b100, 16'h1300, 1'b0);
    tick(); clr_in();
    chk("alias_idx_count", {28'd0, count}, 32'd2);
`else
    set_lane(0, 32'h400, 3'b101, 16'h0400, 1'b1);
    set_lane(1, 32'h400, 3'b010, 16'h0401, 1'b1);
    tick(); clr_in();
    chk("same_idx_count", {28'd0, count}, 32'd2);
    set_lane(0, 32'h300, 3'b001, 16'h0300, 1'b1);
    set_lane(1, 32'h1300, 3'b100, 16'h1300, 1'b1);
    tick(); clr_in();
    chk("alias_idx_count", {28'd0, count}, 32'd4);
`endif
    drain();

    // Reset mid-operation flushes everything, including same-cycle arrivals
    set_lane(0, 32'hE0, 3'b001, 16'h00E0, 1'b1);
    set_lane(1, 32'hE4, 3'b010, 16'h00E4, 1'b1);
    tick(); clr_in();
    chk("pre_rst_count", {28'd0, count}, 32'd2);
    rst = 1'b1;
    out_ready = 1'b1;
    set_lane(0, 32'hF0, 3'b111, 16'h00F0, 1'b0);
    set_lane(1, 32'hF4, 3'b111, 16'h00F4, 1'b0);
    sb.delete();
    tick(); clr_in();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/br_result_queue.md
BR_RESULT_QUEUE -- requirements
Module: br_result_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, number of branch-result lanes arriving per cycle (INT_ISSUE_WIDTH).
REQ-002 SHALL have parameter DEPTH, default 8, number of queue entries; power of two, DEPTH >= 2*LANES.
REQ-003 SHALL have parameter ADDR_W, default 32, branch address width.
REQ-004 SHALL have parameter PV_W, default 16, width of the opaque predictor snapshot (counters plus history).
REQ-005 SHALL have parameter IDX_W, default 9, PHT index width; index = addr[IDX_W+1:2].
REQ-006 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-008 SHALL have port in_valid  in  LANES  per-lane branch result valid.
REQ-009 SHALL have port in_addr  in  LANES*ADDR_W  per-lane branch address (lane 0 in the LSBs).
REQ-010 SHALL have port in_taken / in_mispred / in_cond  in  LANES each  per-lane execTaken, mispred and isCondBr.
REQ-011 SHALL have port in_prev  in  LANES*PV_W  per-lane predictor snapshot captured at fetch.
REQ-012 SHALL have port in_ready  out  1  high when free entries >= LANES.
REQ-013 SHALL have ports out_valid  out  1, out_addr  out  ADDR_W, out_taken/out_mispred/out_cond  out  1 each, out_prev  out  PV_W; head entry.
REQ-014 SHALL have port out_ready  in  1  predictor consumes the head entry this cycle.
REQ-015 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.
REQ-016 SHALL have port overflow  out  1  sticky: a valid lane arrived while in_ready was low.

Function
REQ-017 in_ready SHALL be derived combinationally from the registered count only (count <= DEPTH-LANES), never from out_ready.
REQ-018 When in_ready=1, every valid lane SHALL be written in ascending lane order into consecutive slots from the tail; invalid lanes SHALL leave no hole.
REQ-019 When in_ready=0, all arriving lanes SHALL be discarded and overflow SHALL be set if any in_valid bit is 1.
REQ-020 out_valid SHALL equal (count != 0); out_* SHALL present the head slot with no combinational path from in_*; an entry enqueued in cycle N SHALL be visible at the head no earlier than cycle N+1.
REQ-021 A dequeue SHALL occur iff out_valid && out_ready; out_ready with count=0 SHALL be ignored.
REQ-022 Simultaneous enqueue of k entries and dequeue SHALL update count to count+k-1 in the same edge; the full/empty boundary SHALL not block the dequeue.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; a multi-lane write straddling the wrap SHALL split correctly across slots DEPTH-1 and 0.
REQ-024 Entry order at the output SHALL be strictly FIFO: arrival cycle order, then lane order within a cycle.
REQ-025 Payload fields SHALL be stored unmodified; the block SHALL not interpret in_prev.

Reset
REQ-026 While rst=1 at a clock edge: head=0, tail=0, count=0, overflow=0; input lanes in that cycle SHALL be discarded.
REQ-027 After reset: out_valid=0, in_ready=1, overflow=0; out_* payload values are don't-care while out_valid=0.
REQ-028 rst asserted mid-operation SHALL drop all queued entries in one cycle, with no partial dequeue.

Configuration
REQ-029 Macro BR_RESULT_QUEUE_COALESCE_EN SHALL control same-index coalescing.
REQ-030 Defined: in one cycle, a valid lane whose PHT index equals that of a lower-numbered valid lane in the same cycle SHALL be discarded and not enqueued. This avoids multibank write conflicts downstream.
REQ-031 Undefined: every valid lane SHALL be enqueued regardless of index.

Verification
REQ-032 Reset, then lanes 0/1 valid with addr 0x100/0x104 -> count=2 next cycle; out_addr=0x100, then 0x104 after one dequeue.
REQ-033 in_valid=2'b10 with addr 0x200 -> single entry at the head, out_addr=0x200, count=1.
REQ-034 Fill to count=7 (DEPTH=8), drive two lanes -> in_ready=0, lanes dropped, overflow=1 and stays 1 until rst.
REQ-035 Wrap: tail=7, enqueue two lanes with addr 0xA0/0xA4 -> 0xA0 in slot 7, 0xA4 in slot 0; FIFO order preserved at the output.
REQ-036 count=6, enqueue two lanes and dequeue in the same cycle -> count=7, no overflow.
REQ-037 Lanes with addr 0x400/0x400 -> with COALESCE_EN count += 1; without the macro count += 2.
